vga_timing_gen: RTL and testbench

//  Generates 640x480@60Hz VGA raster timing from the 100 MHz system clock.

---
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Produces 640x480@60Hz VGA raster timing from the 100 MHz system clock.
//   A divider generates the pixel-rate strobe. Horizontal and vertical
//   counters advance on that strobe. Sync and visible-window flags are
//   registered from the next-count values, so they always agree with the
//   hCount/vCount presented in the same cycle.
//
// Ports
//   clk         in   system clock (100 MHz)
//   reset_n     in   asynchronous active-low reset
//   hCount      out  horizontal pixel counter, 0..H_TOTAL-1
//   vCount      out  vertical line counter, 0..V_TOTAL-1
//   bright      out  1 inside the visible window
//   hSync       out  horizontal sync, active low
//   vSync       out  vertical sync, active low
//   pix_en      out  1-clk strobe, once every CLK_DIV clks
//   frame_tick  out  1-clk strobe in the first cycle showing (0,0) after a wrap
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       pix_en,
    output logic       frame_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYN_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYN_W = 10'(V_SYNC);
    localparam logic [9:0] H_VS_W  = 10'(H_VIS_START);
    localparam logic [9:0] H_VE_W  = 10'(H_VIS_END);
    localparam logic [9:0] V_VS_W  = 10'(V_VIS_START);
    localparam logic [9:0] V_VE_W  = 10'(V_VIS_END);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             frame_wrap;

    always_comb begin
        div_nxt    = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        h_nxt      = hCount;
        v_nxt      = vCount;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (hCount == H_LAST) begin
                h_nxt = '0;
                if (vCount == V_LAST) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vCount + 10'd1;
                end
            end else begin
                h_nxt = hCount + 10'd1;
            end
        end
    end

    // Decode uses h_nxt/v_nxt so the registered flags line up with the
    // counters they describe, without a cycle of lag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            hCount     <= '0;
            vCount     <= '0;
            pix_en     <= 1'b0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            hCount     <= h_nxt;
            vCount     <= v_nxt;
            pix_en     <= (div_nxt == DIV_LAST);
            hSync      <= (h_nxt >= H_SYN_W);
            vSync      <= (v_nxt >= V_SYN_W);
            bright     <= (h_nxt >= H_VS_W) && (h_nxt < H_VE_W) &&
                          (v_nxt >= V_VS_W) && (v_nxt < V_VE_W);
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clock and reset: "d" uses the full 640x480 timing
//   and is checked over the first line and a bit more. "s" is a shrunken
//   raster that is checked over whole frames.
//   Raster "s": 20x8 total, hSync low on h 0..2, vSync low on v 0..1,
//   visible h 5..16 and v 3..6, so a frame is 640 clk and 192 bright clk.
//   Per-pixel expectations are queued when stimulus starts. A monitor per
//   instance pops one entry at every pix_en and compares it.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int k;
        int h;
        int v;
        int hs;
        int vs;
        int br;
        int ft;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [9:0] d_h, d_v, s_h, s_v;
    logic d_br, d_hs, d_vs, d_pe, d_ft;
    logic s_br, s_hs, s_vs, s_pe, s_ft;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bcnt = 0;
    bit bright_en = 1'b0;
    int d_ftc = 0;
    int s_ftc = 0;

    pix_t qd[$];
    pix_t qs[$];

    always #5 clk = ~clk;

    vga_timing_gen u_d (
        .clk(clk), .reset_n(reset_n), .hCount(d_h), .vCount(d_v),
        .bright(d_br), .hSync(d_hs), .vSync(d_vs), .pix_en(d_pe),
        .frame_tick(d_ft)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(17),
        .V_TOTAL(8), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(7)
    ) u_s (
        .clk(clk), .reset_n(reset_n), .hCount(s_h), .vCount(s_v),
        .bright(s_br), .hSync(s_hs), .vSync(s_vs), .pix_en(s_pe),
        .frame_tick(s_ft)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_pix(input string tag, input pix_t e, input int h, input int v,
                           input int hs, input int vs, input int br, input int ft);
        checks++;
        if (h != e.h || v != e.v || hs != e.hs || vs != e.vs || br != e.br || ft != e.ft) begin
            errors++;
            $display("FAIL %s pixel %0d: got h=%0d v=%0d hs=%0d vs=%0d br=%0d ft=%0d, expected h=%0d v=%0d hs=%0d vs=%0d br=%0d ft=%0d",
                     tag, e.k, h, v, hs, vs, br, ft, e.h, e.v, e.hs, e.vs, e.br, e.ft);
        end
    endtask

    function automatic pix_t model(int k, int ht, int vt, int hsy, int vsy,
                                   int hvs, int hve, int vvs, int vve);
        pix_t p;
        p.k  = k;
        p.h  = k % ht;
        p.v  = (k / ht) % vt;
        p.hs = (p.h >= hsy) ? 1 : 0;
        p.vs = (p.v >= vsy) ? 1 : 0;
        p.br = (p.h >= hvs && p.h < hve && p.v >= vvs && p.v < vve) ? 1 : 0;
        p.ft = (k > 0 && (k % (ht * vt)) == 0) ? 1 : 0;
        return p;
    endfunction

    task automatic push_all(input int nd, input int ns);
        for (int k = 0; k < nd; k++) qd.push_back(model(k, 800, 525, 96, 2, 144, 784, 35, 515));
        for (int k = 0; k < ns; k++) qs.push_back(model(k, 20, 8, 3, 2, 5, 17, 3, 7));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_d"}, int'({d_h, d_v, d_br, d_hs, d_vs, d_pe, d_ft}), 0);
        chk({tag, "_s"}, int'({s_h, s_v, s_br, s_hs, s_vs, s_pe, s_ft}), 0);
    endtask

    // frame_tick cycles are accumulated over each pixel period, so a
    // stretched or missing pulse shows up in that pixel's comparison.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            d_ftc = 0;
        end else begin
            if (d_ft) d_ftc++;
            if (d_pe) begin
                if (qd.size() > 0)
                    cmp_pix("pix_d", qd.pop_front(), d_h, d_v, d_hs, d_vs, d_br, d_ftc);
                d_ftc = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            s_ftc = 0;
        end else begin
            if (s_ft) s_ftc++;
            if (bright_en && s_br) bcnt++;
            if (s_pe) begin
                if (qs.size() > 0)
                    cmp_pix("pix_s", qs.pop_front(), s_h, s_v, s_hs, s_vs, s_br, s_ftc);
                s_ftc = 0;
            end
        end
    end

    task automatic startup_checks(input int c);
        if (c == 3) begin
            chk("pe_edge3_d", d_pe, 1);
            chk("h_edge3_d", d_h, 0);
            chk("pe_edge3_s", s_pe, 1);
        end
        if (c == 4) begin
            chk("pe_edge4_d", d_pe, 0);
            chk("h_edge4_d", d_h, 1);
            chk("h_edge4_s", s_h, 1);
        end
        if (c == 8) begin
            chk("h_edge8_d", d_h, 2);
            chk("h_edge8_s", s_h, 2);
        end
    endtask

    initial begin
        int rises[$];
        int ticks[$];
        bit prev_hs;
        bit found;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        @(negedge clk);
        push_all(1000, 1000);
        bright_en = 1'b1;
        reset_n = 1'b1;
        prev_hs = 1'b0;

        for (int c = 1; c <= 4000; c++) begin
            @(posedge clk);
            #1;
            startup_checks(c);
            if (d_hs && !prev_hs) rises.push_back(c);
            prev_hs = d_hs;
            if (s_ft) ticks.push_back(c);
            if (c == 3199) begin
                chk("h_before_wrap", d_h, 799);
                chk("v_before_wrap", d_v, 0);
            end
            if (c == 3200) begin
                chk("h_after_wrap", d_h, 0);
                chk("v_after_wrap", d_v, 1);
            end
        end

        chk("cyc_count", cyc, 4000);
        chk("hsync_rises", rises.size(), 2);
        chk("hsync_first_rise", (rises.size() > 0) ? rises[0] : -1, 384);
        chk("hsync_period", (rises.size() > 1) ? rises[1] - rises[0] : -1, 3200);
        chk("frame_ticks", ticks.size(), 6);
        chk("first_tick", (ticks.size() > 0) ? ticks[0] : -1, 640);
        for (int i = 1; i < ticks.size(); i++)
            chk("tick_period", ticks[i] - ticks[i-1], 640);
        chk("bright_clks_6frames", bcnt, 1152);
        chk("qd_drained", qd.size(), 0);
        chk("qs_drained", qs.size(), 0);
        bright_en = 1'b0;

        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk);
            #1;
            if (s_h == 10'd10 && s_v == 10'd4) found = 1'b1;
        end
        chk("mid_position_found", int'(found), 1);

        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        qd.delete();
        qs.delete();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");

        @(negedge clk);
        push_all(10, 320);
        reset_n = 1'b1;
        for (int c = 1; c <= 1300; c++) begin
            @(posedge clk);
            #1;
            startup_checks(c);
        end
        chk("qd_drained_2", qd.size(), 0);
        chk("qs_drained_2", qs.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
